alu_unit: RTL
=============

Name: alu_unit

Overview:
- Registered execute-stage ALU that consumes the 3-bit ALU control code produced by the ALU control decoder and performs the selected operation on two 32-bit operands.
- Uses a valid/ready handshake on both sides, so the pipeline stalls cleanly.
- Single-cycle ops complete with 1-cycle latency. An optional iterative multiplier takes 32 cycles.
- Sits between ID/EX operand muxing and the EX/MEM register.

Parameters:
- WIDTH, 32, operand/result width; multiplier iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- valid_i  input  1  operands + code presented
- ready_o  output  1  unit can accept this cycle
- ALUCtrl_i  input  3  operation code
- data1_i  input  WIDTH  operand A
- data2_i  input  WIDTH  operand B
- valid_o  output  1  result valid
- ready_i  input  1  downstream accepts result
- data_o  output  WIDTH  result
- zero_o  output  1  result == 0
- illegal_o  output  1  code not supported

Behaviour:
- Reset (async, any state, including mid-multiply):
  - state=IDLE; valid_o, data_o, illegal_o = 0; zero_o = 1.
  - Any in-flight operation is dropped.
- Codes:
  - 010 add; 110 sub (A-B).
  - 000 AND; 001 OR.
  - 111 slt: 1 if $signed(A) < $signed(B), else 0.
  - 011 mul (optional, see below).
  - 100 and 101 are illegal.
- Arithmetic: add/sub/mul wrap modulo 2^WIDTH; no overflow flag; mul keeps the low WIDTH bits of the product.
- ready_o = (state==IDLE) && (!valid_o || ready_i). This is combinational and allows back-to-back issue.
- Accept occurs on a rising edge with valid_i && ready_o. Operands and code are captured only at accept.
- Output hold: while valid_o && !ready_i, data_o/zero_o/illegal_o stay stable.
- Output release: on a ready_i edge with no new completion, valid_o falls.
- Single-cycle op or illegal code: result is registered on the accept edge; valid_o=1 the next cycle (latency 1).
  - Throughput is 1/cycle when ready_i is held high.
  - Accept and consume on the same edge: the new result replaces the old one and valid_o stays 1.
- Illegal code: data_o=0, zero_o=1, illegal_o=1, 1-cycle latency. illegal_o=0 for all legal codes.
- zero_o is registered together with data_o.
- States:
  - IDLE: accept single-cycle ops, or go to MUL on code 011 (when enabled).
  - MUL: ready_o=0; shift-add iterations; return to IDLE on completion.
- valid_i while ready_o=0 is ignored. The upstream must hold it; no capture occurs.

Optional Feature:
- Macro: ALU_UNIT_MUL_EN.
- Defined:
  - Code 011 is an unsigned shift-add multiply.
  - Accept edge N loads multiplicand, multiplier and accumulator=0, and sets the counter to WIDTH-1.
  - Edges N+1..N+WIDTH each perform one iteration: if multiplier LSB, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1.
  - The last iteration (counter==0) writes data_o, sets valid_o=1 and returns to IDLE. valid_o is high after edge N+WIDTH.
  - The output slot is empty at accept by construction (ready_o rule), so valid_o=0 throughout MUL.
- Undefined: code 011 is illegal (1-cycle, data_o=0, illegal_o=1); no MUL state or multiplier registers exist.

Test Plan:
- Reset: assert rst_i mid-stream -> immediately valid_o=0, data_o=0, zero_o=1, ready_o=1.
- Add/sub wrap and zero:
  - 010, A=0xFFFFFFFF, B=1 -> next cycle data_o=0, zero_o=1, valid_o=1.
  - 110, A=5, B=7 -> data_o=0xFFFFFFFE, zero_o=0.
- Logic and slt:
  - 000, 0xF0F0_0000 & 0xFF00_FF00 -> 0xF000_0000.
  - 001, 0x0000_00F0 | 0x0F -> 0xFF.
  - 111, A=0xFFFFFFFF (-1), B=1 -> 1; A=1, B=0xFFFFFFFF -> 0.
- Backpressure: issue 3 adds back-to-back with ready_i=0 after the first -> valid_o held, data_o stable, ready_o=0. Raise ready_i -> remaining results emerge in order, one per cycle.
- Illegal: code 101, A=3, B=4 -> next cycle data_o=0, illegal_o=1, zero_o=1. Without MUL_EN, code 011 gives the same response.
- With MUL_EN:
  - 011, A=0x0001_0003, B=0x0000_0005 -> ready_o=0 for 32 cycles, then data_o=0x0005_000F, valid_o=1.
  - A=0xFFFFFFFF, B=2 -> 0xFFFFFFFE.
  - rst_i at iteration 10 -> IDLE, no result emitted.

Source files
------------

// File: rtl/alu_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_unit                                                         |
// | Brief   : Registered execute-stage ALU with valid/ready handshake on both  |
// |           sides; optional iterative multiplier via ALU_UNIT_MUL_EN.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             illegal_o
);

    localparam logic [2:0] c_op_and = 3'b000;
    localparam logic [2:0] c_op_or  = 3'b001;
    localparam logic [2:0] c_op_add = 3'b010;
    localparam logic [2:0] c_op_mul = 3'b011;
    localparam logic [2:0] c_op_sub = 3'b110;
    localparam logic [2:0] c_op_slt = 3'b111;

    logic [WIDTH-1:0] r_data;
    logic             r_zero;
    logic             r_illegal;
    logic             r_valid;

    logic [WIDTH-1:0] w_result;
    logic             w_illegal;
    logic             w_is_mul;
    logic             w_idle;
    logic             w_accept;
    logic             w_load_single;

    // Single-cycle datapath; code 011 is treated as illegal unless the multiplier is built.
    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        case (ALUCtrl_i)
            c_op_and: w_result = data1_i & data2_i;
            c_op_or:  w_result = data1_i | data2_i;
            c_op_add: w_result = data1_i + data2_i;
            c_op_sub: w_result = data1_i - data2_i;
            c_op_slt: w_result = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
`ifdef ALU_UNIT_MUL_EN
            c_op_mul: w_is_mul = 1'b1;
`endif
            default:  w_illegal = 1'b1;
        endcase
    end

    assign ready_o       = w_idle && (!r_valid || ready_i);
    assign w_accept      = valid_i && ready_o;
    assign w_load_single = w_accept && !w_is_mul;

`ifdef ALU_UNIT_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_mul_done;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == '0);
    assign w_idle     = (r_state == S_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_mul) w_state_next = S_MUL;
            S_MUL:   if (r_cnt == '0) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shift-add iteration: one multiplier bit per cycle, low WIDTH bits kept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= data1_i;
            r_mplier <= data2_i;
            r_acc    <= '0;
            r_cnt    <= c_cnt_last;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - 1'b1;
        end
    end
`else
    assign w_idle = 1'b1;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data    <= '0;
            r_zero    <= 1'b1;
            r_illegal <= 1'b0;
            r_valid   <= 1'b0;
        end else if (w_load_single) begin
            r_data    <= w_result;
            r_zero    <= (w_result == '0);
            r_illegal <= w_illegal;
            r_valid   <= 1'b1;
`ifdef ALU_UNIT_MUL_EN
        end else if (w_mul_done) begin
            r_data    <= w_acc_next;
            r_zero    <= (w_acc_next == '0);
            r_illegal <= 1'b0;
            r_valid   <= 1'b1;
`endif
        end else if (ready_i) begin
            r_valid   <= 1'b0;
        end
    end

    assign valid_o   = r_valid;
    assign data_o    = r_data;
    assign zero_o    = r_zero;
    assign illegal_o = r_illegal;

endmodule
`default_nettype wire
